// File: rtl/os_tile_array.sv
// Output-stationary ROWS x COLS MAC array: skewed operand feed, saturating
// accumulators, row-by-row result drain over a valid/ready handshake.
module os_tile_array #(
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int AK_BW  = 20,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_BW   = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [K_BW-1:0]            i_k_len,
  input  logic                       i_signed,
  input  logic                       i_acc_keep,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [I_F_BW*ROWS-1:0]     i_fmap,
  input  logic [W_BW*COLS-1:0]       i_weight,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [AK_BW*COLS-1:0]      o_res,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] o_row_idx,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_sat
);
  localparam int P_BW  = I_F_BW + W_BW;
  localparam int RI_BW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SK    = ROWS + COLS - 1;
  localparam int FL_BW = $clog2(ROWS + COLS) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FLUSH = 2'd2, S_DRAIN = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [K_BW-1:0]    k_len_q, k_len_d, beat_q, beat_d;
  logic               signed_q, signed_d, sat_q, sat_d, done_q, done_d;
  logic [FL_BW-1:0]   fl_q, fl_d;
  logic [RI_BW-1:0]   row_q, row_d;
  // Per-row / per-column shift chains; PE(r,c) taps stage r+c of both.
  logic [I_F_BW-1:0]  h_q [ROWS][SK];
  logic [I_F_BW-1:0]  h_d [ROWS][SK];
  logic               hv_q [ROWS][SK];
  logic               hv_d [ROWS][SK];
  logic [W_BW-1:0]    v_q [COLS][SK];
  logic [W_BW-1:0]    v_d [COLS][SK];
  logic [AK_BW-1:0]   acc_q [ROWS][COLS];
  logic [AK_BW-1:0]   acc_d [ROWS][COLS];
  logic [AK_BW:0]     mac_res;
  logic               feed_v;
  logic [AK_BW*COLS-1:0] res_s;

  function automatic logic [P_BW-1:0] mul_ext(input logic [I_F_BW-1:0] a,
                                              input logic [W_BW-1:0] b, input logic sgn);
    logic [P_BW-1:0] a_x, b_x;
    a_x = sgn ? {{W_BW{a[I_F_BW-1]}}, a} : {{W_BW{1'b0}}, a};
    b_x = sgn ? {{I_F_BW{b[W_BW-1]}}, b} : {{I_F_BW{1'b0}}, b};
    return a_x * b_x;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [AK_BW:0] sat_add(input logic [AK_BW-1:0] acc,
                                             input logic [P_BW-1:0] prod, input logic sgn);
    logic [AK_BW:0] a_x, p_x, sum, res;
    a_x = sgn ? {acc[AK_BW-1], acc} : {1'b0, acc};
    p_x = sgn ? {{(AK_BW+1-P_BW){prod[P_BW-1]}}, prod} : {{(AK_BW+1-P_BW){1'b0}}, prod};
    sum = a_x + p_x;
    if (sgn) begin
      if (sum[AK_BW] != sum[AK_BW-1]) begin
        res = {1'b1, sum[AK_BW] ? {1'b1, {(AK_BW-1){1'b0}}} : {1'b0, {(AK_BW-1){1'b1}}}};
      end else begin
        res = {1'b0, sum[AK_BW-1:0]};
      end
    end else begin
      if (sum[AK_BW]) begin
        res = {1'b1, {AK_BW{1'b1}}};
      end else begin
        res = {1'b0, sum[AK_BW-1:0]};
      end
    end
    return res;
  endfunction

  // Next-state: skew chains, MAC array, control FSM.
  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    beat_d   = beat_q;
    signed_d = signed_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    fl_d     = fl_q;
    row_d    = row_q;
    acc_d    = acc_q;
    mac_res  = {(AK_BW+1){1'b0}};
    feed_v   = (state_q == S_LOAD) & i_valid;

    for (int r = 0; r < ROWS; r++) begin
      h_d[r][0]  = i_fmap[r*I_F_BW +: I_F_BW];
      hv_d[r][0] = feed_v;
      for (int j = 1; j < SK; j++) begin
        h_d[r][j]  = h_q[r][j-1];
        hv_d[r][j] = hv_q[r][j-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      v_d[c][0] = i_weight[c*W_BW +: W_BW];
      for (int j = 1; j < SK; j++) begin
        v_d[c][j] = v_q[c][j-1];
      end
    end

    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (hv_q[r][r+c]) begin
          mac_res     = sat_add(acc_q[r][c], mul_ext(h_q[r][r+c], v_q[c][r+c], signed_q), signed_q);
          acc_d[r][c] = mac_res[AK_BW-1:0];
          sat_d       = sat_d | mac_res[AK_BW];
        end else begin
          acc_d[r][c] = acc_q[r][c];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_len_d  = i_k_len;
          signed_d = i_signed;
          beat_d   = {K_BW{1'b0}};
          fl_d     = {FL_BW{1'b0}};
          row_d    = {RI_BW{1'b0}};
          if (!i_acc_keep) begin
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                acc_d[r][c] = {AK_BW{1'b0}};
              end
            end
            sat_d = 1'b0;
          end else begin
            sat_d = sat_q;
          end
          state_d = (i_k_len == {K_BW{1'b0}}) ? S_DRAIN : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (i_valid) begin
          beat_d = beat_q + K_BW'(1);
          if ((beat_q + K_BW'(1)) == k_len_q) begin
            state_d = S_FLUSH;
            fl_d    = {FL_BW{1'b0}};
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        if (fl_q == FL_BW'(ROWS + COLS - 2)) begin
          state_d = S_DRAIN;
          row_d   = {RI_BW{1'b0}};
        end else begin
          fl_d = fl_q + FL_BW'(1);
        end
      end
      S_DRAIN: begin
        if (i_res_ready) begin
          if (row_q == RI_BW'(ROWS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            row_d   = {RI_BW{1'b0}};
          end else begin
            row_d = row_q + RI_BW'(1);
          end
        end else begin
          row_d = row_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      k_len_q  <= {K_BW{1'b0}};
      beat_q   <= {K_BW{1'b0}};
      signed_q <= 1'b0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
      fl_q     <= {FL_BW{1'b0}};
      row_q    <= {RI_BW{1'b0}};
      for (int r = 0; r < ROWS; r++) begin
        for (int j = 0; j < SK; j++) begin
          h_q[r][j]  <= {I_F_BW{1'b0}};
          hv_q[r][j] <= 1'b0;
        end
        for (int c = 0; c < COLS; c++) begin
          acc_q[r][c] <= {AK_BW{1'b0}};
        end
      end
      for (int c = 0; c < COLS; c++) begin
        for (int j = 0; j < SK; j++) begin
          v_q[c][j] <= {W_BW{1'b0}};
        end
      end
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      beat_q   <= beat_d;
      signed_q <= signed_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
      fl_q     <= fl_d;
      row_q    <= row_d;
      h_q      <= h_d;
      hv_q     <= hv_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
    end
  end

  // Result row mux, zero outside DRAIN.
  always_comb begin
    res_s = {(AK_BW*COLS){1'b0}};
    if (state_q == S_DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        res_s[c*AK_BW +: AK_BW] = acc_q[row_q][c];
      end
    end else begin
      res_s = {(AK_BW*COLS){1'b0}};
    end
  end

  assign o_res       = res_s;
  assign o_row_idx   = row_q;
  assign o_ready     = (state_q == S_LOAD);
  assign o_res_valid = (state_q == S_DRAIN);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_sat       = sat_q;
endmodule

// File: tb/tb_os_tile_array.sv
// Directed bench for os_tile_array: a reference accumulator model fills a
// scoreboard of expected result rows, compared as the array drains them.
module tb_os_tile_array;
  localparam int I_F_BW = 8;
  localparam int W_BW   = 8;
  localparam int AK_BW  = 20;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int K_BW   = 9;
  localparam int RW     = AK_BW * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_start = 1'b0, i_signed = 1'b0, i_acc_keep = 1'b0, i_valid = 1'b0;
  logic i_res_ready = 1'b1;
  logic [K_BW-1:0] i_k_len = '0;
  logic [I_F_BW*ROWS-1:0] i_fmap = '0;
  logic [W_BW*COLS-1:0] i_weight = '0;
  logic o_ready, o_res_valid, o_busy, o_done, o_sat;
  logic [RW-1:0] o_res;
  logic [1:0] o_row_idx;

  os_tile_array #(.I_F_BW(I_F_BW), .W_BW(W_BW), .AK_BW(AK_BW), .ROWS(ROWS),
                  .COLS(COLS), .K_BW(K_BW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len),
    .i_signed(i_signed), .i_acc_keep(i_acc_keep), .i_valid(i_valid),
    .o_ready(o_ready), .i_fmap(i_fmap), .i_weight(i_weight),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res(o_res),
    .o_row_idx(o_row_idx), .o_busy(o_busy), .o_done(o_done), .o_sat(o_sat));

  always #5 clk = ~clk;

  typedef struct { int idx; logic [RW-1:0] data; } row_t;
  row_t   sbq[$];
  longint mdl [ROWS][COLS];
  bit     mdl_sat;
  int     tests = 0;
  int     fails = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fval(int fb, bit vary, int b, int r);
    return 8'(fb + (vary ? (r * 3 + b) : 0));
  endfunction

  function automatic logic [7:0] wval(int wb, bit vary, int b, int c);
    return 8'(wb + (vary ? (c * 5 + 2 * b) : 0));
  endfunction

  function automatic longint mstep(input longint raw, input longint prod, input bit sgn, output bit s);
    longint half, full, a, sum, lo, hi;
    half = longint'(1) << (AK_BW - 1);
    full = longint'(1) << AK_BW;
    a = (sgn && raw >= half) ? raw - full : raw;
    sum = a + prod;
    lo = sgn ? -half : 0;
    hi = sgn ? half - 1 : full - 1;
    s = 1'b0;
    if (sum > hi) begin sum = hi; s = 1'b1; end
    else if (sum < lo) begin sum = lo; s = 1'b1; end
    return sum & (full - 1);
  endfunction

  task automatic model_beat(input int b, input bit sgn, input int fb, input int wb, input bit vary);
    longint fi, wi;
    bit s;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        fi = sgn ? longint'($signed(fval(fb, vary, b, r))) : longint'(fval(fb, vary, b, r));
        wi = sgn ? longint'($signed(wval(wb, vary, b, c))) : longint'(wval(wb, vary, b, c));
        mdl[r][c] = mstep(mdl[r][c], fi * wi, sgn, s);
        if (s) mdl_sat = 1'b1;
      end
    end
  endtask

  task automatic drive_beat(input int b, input int fb, input int wb, input bit vary);
    for (int r = 0; r < ROWS; r++) i_fmap[r*I_F_BW +: I_F_BW] = fval(fb, vary, b, r);
    for (int c = 0; c < COLS; c++) i_weight[c*W_BW +: W_BW] = wval(wb, vary, b, c);
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = 0;
    mdl_sat = 1'b0;
  endtask

  task automatic run_job(input string name, input int k, input bit sgn, input bit keep,
                         input int fb, input int wb, input bit vary, input bit bubbles, input int stall);
    int sent, cyc;
    bit v, acc;
    row_t e;
    logic [5:0] pat;
    pat = 6'b101001;
    cyc = 0;
    while (o_busy && cyc < 200) begin tick(); cyc++; end
    chk({name, " idle"}, RW'(o_busy), RW'(0));
    i_start = 1'b1; i_k_len = K_BW'(k); i_signed = sgn; i_acc_keep = keep;
    i_valid = 1'b1; i_fmap = {ROWS{8'hA5}}; i_weight = {COLS{8'h5A}};
    tick();
    i_start = 1'b0; i_valid = 1'b0;
    if (!keep) clear_model();
    chk({name, " busy"}, RW'(o_busy), RW'(1));
    sent = 0; cyc = 0;
    while (sent < k && cyc < 1000) begin
      v = bubbles ? pat[cyc % 6] : 1'b1;
      drive_beat(sent, fb, wb, vary);
      i_valid = v;
      acc = v && o_ready;
      tick();
      cyc++;
      if (acc) begin
        model_beat(sent, sgn, fb, wb, vary);
        sent++;
      end
    end
    i_valid = 1'b0;
    if (k > 0) begin
      chk({name, " beats"}, RW'(sent), RW'(k));
      chk({name, " ready drop"}, RW'(o_ready), RW'(0));
      i_start = 1'b1; i_k_len = '0; i_acc_keep = 1'b0;
      repeat (ROWS + COLS - 2) tick();
      chk({name, " flush len"}, RW'(o_res_valid), RW'(0));
      tick();
      i_start = 1'b0;
    end
    chk({name, " drain start"}, RW'(o_res_valid), RW'(1));
    for (int r = 0; r < ROWS; r++) begin
      e.idx = r;
      e.data = '0;
      for (int c = 0; c < COLS; c++) e.data[c*AK_BW +: AK_BW] = AK_BW'(mdl[r][c]);
      sbq.push_back(e);
    end
    for (int r = 0; r < ROWS; r++) begin
      e = sbq.pop_front();
      chk({name, " row idx"}, RW'(o_row_idx), RW'(e.idx));
      chk({name, " row data"}, o_res, e.data);
      if (e.idx == 1 && stall > 0) begin
        i_res_ready = 1'b0;
        repeat (stall) begin
          tick();
          chk({name, " held idx"}, RW'(o_row_idx), RW'(1));
          chk({name, " held data"}, o_res, e.data);
        end
      end
      i_res_ready = 1'b1;
      tick();
    end
    chk({name, " done"}, RW'({o_done, o_res_valid, o_busy}), RW'(3'b100));
    chk({name, " sat"}, RW'(o_sat), RW'(mdl_sat));
    tick();
    chk({name, " done pulse"}, RW'(o_done), RW'(0));
  endtask

  initial begin
    repeat (3) tick();
    chk("reset outs", RW'({o_ready, o_busy, o_res_valid, o_done, o_sat, o_row_idx}), RW'(0));
    chk("reset res", o_res, RW'(0));
    rst_n = 1'b0;
    tick();
    clear_model();

    run_job("basic",    1,  1'b0, 1'b0, 2,    3,   1'b0, 1'b0, 0);
    run_job("signed",   4,  1'b1, 1'b0, 8'hFF, 127, 1'b0, 1'b0, 0);
    run_job("unsigned", 4,  1'b0, 1'b0, 8'hFF, 127, 1'b0, 1'b0, 0);
    run_job("varied",   5,  1'b1, 1'b0, 8'hF0, 5,   1'b1, 1'b0, 0);
    run_job("sat_s",    64, 1'b1, 1'b0, 127,  127, 1'b0, 1'b0, 0);
    run_job("bubbles",  3,  1'b0, 1'b0, 1,    1,   1'b0, 1'b1, 5);
    run_job("acc_a",    1,  1'b0, 1'b0, 2,    3,   1'b0, 1'b0, 0);
    run_job("acc_b",    1,  1'b0, 1'b1, 2,    3,   1'b0, 1'b0, 0);
    run_job("acc_c",    1,  1'b0, 1'b0, 2,    3,   1'b0, 1'b0, 0);
    run_job("sat_u",    17, 1'b0, 1'b0, 255,  255, 1'b0, 1'b0, 0);

    // Abort: sticky saturation and partial sums must vanish on reset.
    i_start = 1'b1; i_k_len = K_BW'(5); i_signed = 1'b0; i_acc_keep = 1'b1;
    tick();
    i_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(b, 9, 7, 1'b1);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    chk("abort pre sat", RW'(o_sat), RW'(1));
    rst_n = 1'b1;
    #1;
    chk("abort outs", RW'({o_ready, o_busy, o_res_valid, o_done, o_sat, o_row_idx}), RW'(0));
    chk("abort res", o_res, RW'(0));
    #2;
    rst_n = 1'b0;
    clear_model();
    tick();
    run_job("zero", 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
